// File: rtl/conva5_ofm_pkg.sv
// Shared encodings and pass-count derivation for the conv A5 output feature-map buffer.
package conva5_ofm_pkg;

  // Input feature depth and number of parallel conv units per pass.
  localparam int unsigned OFM_INPUT_DEPTH = 88;
  localparam int unsigned OFM_CONV_UNITS  = 3;

  // Integer ceiling division used to size the accumulation pass count.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Accumulation passes needed to cover the full input depth.
  localparam int unsigned OFM_PASSES = ceil_div(OFM_INPUT_DEPTH, OFM_CONV_UNITS);

  // Buffer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } ofm_state_t;

endpackage

// File: rtl/ofm_dual_port_memory.sv
// Partial-sum storage: one write port, one synchronous read port, contents never reset.
module ofm_dual_port_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 160,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write and registered read; a same-address read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/conva5_ofm_buffer.sv
// Output feature-map buffer: accumulates per-filter partial sums over several passes,
// feeds them back to the conv accumulator, then streams the final results downstream.
module conva5_ofm_buffer
  import conva5_ofm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned NUMBER_OF_FILTERS = 160,
  parameter int unsigned NUMBER_OF_PASSES  = OFM_PASSES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] data_out_for_previous,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_error
);

  localparam int unsigned AW = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1;
  localparam int unsigned DW = $clog2(NUMBER_OF_FILTERS + 1);
  localparam int unsigned PW = $clog2(NUMBER_OF_PASSES + 1);

  ofm_state_t            state, state_d;
  logic [AW-1:0]         wr_ptr, wr_ptr_d;
  logic [AW-1:0]         rd_ptr, rd_ptr_d;
  logic [PW-1:0]         pass_cnt, pass_cnt_d;
  logic [DW-1:0]         drain_addr, drain_addr_d;
  logic                  mid_valid, mid_valid_d;
  logic                  mid_last, mid_last_d;
  logic                  out_valid_d, out_last_d, busy_d, done_d, overflow_d;
  logic [DATA_WIDTH-1:0] out_data_d;
  logic                  prev_live, prev_live_d;
  logic [DATA_WIDTH-1:0] prev_hold;

  logic                  mem_we, mem_re;
  logic [AW-1:0]         mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  consume, load_out, issue;

  ofm_dual_port_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUMBER_OF_FILTERS),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (mem_re),
    .rd_addr (mem_raddr),
    .rd_data (mem_rdata)
  );

  // Feedback word: fresh memory data the cycle after an accumulation read, held otherwise.
  assign data_out_for_previous = prev_live ? mem_rdata : prev_hold;

  // Next-state, pointer, drain pipeline and flag logic.
  always_comb begin
    state_d      = state;
    wr_ptr_d     = wr_ptr;
    rd_ptr_d     = rd_ptr;
    pass_cnt_d   = pass_cnt;
    drain_addr_d = drain_addr;
    mid_valid_d  = mid_valid;
    mid_last_d   = mid_last;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    out_last_d   = out_last;
    done_d       = 1'b0;
    overflow_d   = overflow_error | (wr_enable && (state != ST_ACCUM));
    prev_live_d  = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_raddr    = rd_ptr;
    consume      = 1'b0;
    load_out     = 1'b0;
    issue        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ACCUM;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          pass_cnt_d = '0;
        end
      end

      ST_ACCUM: begin
        if (rd_enable) begin
          mem_re      = 1'b1;
          prev_live_d = 1'b1;
          rd_ptr_d    = (rd_ptr == AW'(NUMBER_OF_FILTERS - 1)) ? '0 : rd_ptr + AW'(1);
        end
        if (wr_enable) begin
          mem_we = 1'b1;
          if (wr_ptr == AW'(NUMBER_OF_FILTERS - 1)) begin
            wr_ptr_d   = '0;
            pass_cnt_d = pass_cnt + PW'(1);
            if (pass_cnt == PW'(NUMBER_OF_PASSES - 1)) begin
              state_d      = ST_DRAIN;
              drain_addr_d = '0;
              mid_valid_d  = 1'b0;
            end
          end else begin
            wr_ptr_d = wr_ptr + AW'(1);
          end
        end
      end

      ST_DRAIN: begin
        // The memory read register doubles as the skid slot between read and output.
        mem_raddr = drain_addr[AW-1:0];
        consume   = out_valid && out_ready;
        load_out  = mid_valid && (!out_valid || consume);
        issue     = (drain_addr != DW'(NUMBER_OF_FILTERS)) && (!mid_valid || load_out);
        if (consume) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (load_out) begin
          out_valid_d = 1'b1;
          out_data_d  = mem_rdata;
          out_last_d  = mid_last;
        end
        if (issue) begin
          mem_re       = 1'b1;
          mid_last_d   = (drain_addr == DW'(NUMBER_OF_FILTERS - 1));
          drain_addr_d = drain_addr + DW'(1);
          mid_valid_d  = 1'b1;
        end else if (load_out) begin
          mid_valid_d = 1'b0;
        end
        if (consume && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; memory contents are left untouched by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pass_cnt       <= '0;
      drain_addr     <= '0;
      mid_valid      <= 1'b0;
      mid_last       <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow_error <= 1'b0;
      prev_live      <= 1'b0;
      prev_hold      <= '0;
    end else begin
      state          <= state_d;
      wr_ptr         <= wr_ptr_d;
      rd_ptr         <= rd_ptr_d;
      pass_cnt       <= pass_cnt_d;
      drain_addr     <= drain_addr_d;
      mid_valid      <= mid_valid_d;
      mid_last       <= mid_last_d;
      out_valid      <= out_valid_d;
      out_data       <= out_data_d;
      out_last       <= out_last_d;
      busy           <= busy_d;
      done           <= done_d;
      overflow_error <= overflow_d;
      prev_live      <= prev_live_d;
      prev_hold      <= data_out_for_previous;
    end
  end

endmodule

// File: tb/tb_conva5_ofm_buffer.sv
// Scoreboard bench: a small 4-filter/3-pass buffer with directed and random frames,
// plus a default-sized buffer checked for a gap-free 160-word drain.
module tb_conva5_ofm_buffer;

  localparam int NF  = 4;
  localparam int NP  = 3;
  localparam int DNF = 160;
  localparam int DNP = 30;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // Small instance signals
  logic        s_start = 0, s_wr = 0, s_rd = 0, s_ready = 1;
  logic [31:0] s_din = 0;
  logic [31:0] s_prev, s_odata;
  logic        s_ovalid, s_olast, s_busy, s_done, s_ovf;

  // Default instance signals
  logic        d_start = 0, d_wr = 0, d_rd = 0, d_ready = 1;
  logic [31:0] d_din = 0;
  logic [31:0] d_prev, d_odata;
  logic        d_ovalid, d_olast, d_busy, d_done, d_ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state (small instance)
  int          m_mode = 0;  // 0 idle, 1 accumulating, 2 draining
  int          m_wp = 0, m_rp = 0, m_pass = 0;
  logic        m_ovf = 0;
  logic [31:0] ref_mem [NF];
  exp_t        s_exp_q [$];
  logic [31:0] exp_prev_q [$];
  logic [31:0] exp_hold = 0;
  logic        prev_acc = 0, prev_due = 0;

  // Monitor state
  int          s_xfers = 0, s_done_cnt = 0;
  logic        s_hold_chk = 0, s_hold_last = 0;
  logic [31:0] s_hold_data = 0;

  // Default instance model
  logic [31:0] d_ref [DNF];
  exp_t        d_exp_q [$];
  int          d_xfers = 0, d_last_cyc = 0;

  conva5_ofm_buffer #(.DATA_WIDTH(32), .NUMBER_OF_FILTERS(NF), .NUMBER_OF_PASSES(NP)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .wr_enable(s_wr), .data_in(s_din),
    .rd_enable(s_rd), .data_out_for_previous(s_prev), .out_valid(s_ovalid),
    .out_ready(s_ready), .out_data(s_odata), .out_last(s_olast), .busy(s_busy),
    .done(s_done), .overflow_error(s_ovf)
  );

  conva5_ofm_buffer dut_d (
    .clk(clk), .reset(reset), .start(d_start), .wr_enable(d_wr), .data_in(d_din),
    .rd_enable(d_rd), .data_out_for_previous(d_prev), .out_valid(d_ovalid),
    .out_ready(d_ready), .out_data(d_odata), .out_last(d_olast), .busy(d_busy),
    .done(d_done), .overflow_error(d_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One stimulus cycle on the small instance, with the model advanced alongside.
  task automatic s_cycle(input logic st, input logic wr, input logic rd,
                         input logic [31:0] din, input logic rdy);
    int mode_b;
    @(posedge clk); #1;
    s_start = st; s_wr = wr; s_rd = rd; s_din = din; s_ready = rdy;
    prev_acc = 1'b0;
    mode_b = m_mode;
    if (wr && mode_b != 1) m_ovf = 1'b1;
    if (mode_b == 0 && st) begin
      m_mode = 1; m_wp = 0; m_rp = 0; m_pass = 0;
    end else if (mode_b == 1) begin
      if (rd) begin
        exp_prev_q.push_back(ref_mem[m_rp]);
        prev_acc = 1'b1;
        m_rp = (m_rp + 1) % NF;
      end
      if (wr) begin
        ref_mem[m_wp] = din;
        m_wp++;
        if (m_wp == NF) begin
          m_wp = 0;
          m_pass++;
          if (m_pass == NP) begin
            m_mode = 2;
            for (int k = 0; k < NF; k++) s_exp_q.push_back('{ref_mem[k], k == NF - 1});
          end
        end
      end
    end
  endtask

  // Drain the small instance: mode 0 ready high, 1 random ready with stray writes, 2 stall on word 2.
  task automatic s_drain(input int mode);
    int seen0, d0, n, stall;
    logic rdy, wr;
    seen0 = s_xfers; d0 = s_done_cnt; n = 0; stall = 3;
    while ((s_xfers - seen0) < NF && n < 200) begin
      rdy = 1'b1; wr = 1'b0;
      if (mode == 1) begin
        rdy = 1'($urandom_range(0, 1));
        wr  = ($urandom_range(0, 7) == 0);
      end else if (mode == 2 && (s_xfers - seen0) == 1 && stall > 0) begin
        rdy = 1'b0;
        stall--;
      end
      s_cycle(1'b0, wr, 1'($urandom_range(0, 1)), $urandom | 32'h0001_0000, rdy);
      if (mode == 2 && !rdy) begin
        @(negedge clk);
        chk("stall_valid", s_ovalid, 1);
        if (s_exp_q.size() > 0) chk("stall_data", s_odata, s_exp_q[0].data);
      end
      n++;
    end
    chk("drain_xfers", s_xfers - seen0, NF);
    m_mode = 0;
    for (int i = 0; i < 4; i++) s_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("done_pulses", s_done_cnt - d0, 1);
    chk("busy_after", s_busy, 0);
    chk("overflow", s_ovf, m_ovf);
  endtask

  // Directed frame: passes of 1..4, 11..14, 21..24 with feedback reads in passes 2 and 3.
  task automatic s_fixed_frame(input int mode);
    s_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int p = 0; p < NP; p++)
      for (int f = 0; f < NF; f++)
        s_cycle(1'b0, 1'b1, p > 0, 32'(10 * p + f + 1), 1'b1);
    s_drain(mode);
  endtask

  // Random frame with idle gaps, random feedback reads and ignored mid-frame starts.
  task automatic s_random_frame();
    int gap;
    s_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < NP * NF; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        s_cycle($urandom_range(0, 9) == 0, 1'b0, 1'($urandom_range(0, 1)), 32'h0, 1'b1);
      s_cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom | 32'h0001_0000, 1'b1);
    end
    s_drain(1);
  endtask

  // Small instance monitor: output scoreboard, stall stability, done count, feedback word.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      s_hold_chk = 1'b0;
    end else begin
      if (s_hold_chk) begin
        chk("hold_valid", s_ovalid, 1);
        chk("hold_data", s_odata, s_hold_data);
        chk("hold_last", s_olast, s_hold_last);
      end
      if (s_ovalid && s_ready) begin
        if (s_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got %0h expected none", s_odata);
        end else begin
          e = s_exp_q.pop_front();
          chk("out_data", s_odata, e.data);
          chk("out_last", s_olast, e.last);
        end
        s_xfers++;
      end
      s_hold_chk  = s_ovalid && !s_ready;
      s_hold_data = s_odata;
      s_hold_last = s_olast;
      if (s_done) s_done_cnt++;
      if (prev_due && exp_prev_q.size() > 0) exp_hold = exp_prev_q.pop_front();
      chk("prev_data", s_prev, exp_hold);
      prev_due = prev_acc;
    end
  end

  // Default instance monitor: scoreboard and back-to-back transfer check.
  always @(negedge clk) begin
    exp_t e;
    if (reset && d_ovalid && d_ready) begin
      if (d_xfers > 0) chk("d_gap", cyc - d_last_cyc, 1);
      if (d_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL d_unexpected_out: got %0h expected none", d_odata);
      end else begin
        e = d_exp_q.pop_front();
        chk("d_out_data", d_odata, e.data);
        chk("d_out_last", d_olast, e.last);
      end
      d_last_cyc = cyc;
      d_xfers++;
    end
  end

  initial begin
    int n;
    for (int k = 0; k < NF; k++) ref_mem[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prev", s_prev, 0);
    chk("rst_valid", s_ovalid, 0);
    chk("rst_data", s_odata, 0);
    chk("rst_last", s_olast, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_d_valid", d_ovalid, 0);
    reset = 1'b1;

    s_fixed_frame(0);
    s_fixed_frame(2);

    // Write and read in IDLE: no memory effect, sticky overflow.
    s_cycle(1'b0, 1'b1, 1'b0, 32'd99, 1'b1);
    s_cycle(1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    s_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("idle_ovf", s_ovf, 1);
    chk("idle_busy", s_busy, 0);
    for (int r = 0; r < 3; r++) s_random_frame();

    // Full-size frame on the default instance with ready held high.
    s_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1 d_start = 1'b1;
    @(posedge clk); #1 d_start = 1'b0;
    for (int p = 0; p < DNP; p++)
      for (int f = 0; f < DNF; f++) begin
        @(posedge clk); #1;
        d_wr = 1'b1; d_din = $urandom; d_ref[f] = d_din;
        if (p == DNP - 1 && f == DNF - 1)
          for (int k = 0; k < DNF; k++) d_exp_q.push_back('{d_ref[k], k == DNF - 1});
      end
    @(posedge clk); #1 d_wr = 1'b0;
    n = 0;
    while (d_xfers < DNF && n < 400) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("d_xfers", d_xfers, DNF);
    chk("d_busy", d_busy, 0);
    chk("d_ovf", d_ovf, 0);

    // Reset in pass 2 before the address 1 write, then a clean frame.
    s_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int f = 0; f < NF; f++) s_cycle(1'b0, 1'b1, 1'b0, 32'(f + 101), 1'b1);
    s_cycle(1'b0, 1'b1, 1'b1, 32'd111, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    s_start = 0; s_wr = 0; s_rd = 0;
    m_mode = 0; m_ovf = 1'b0; exp_hold = '0; prev_acc = 1'b0; prev_due = 1'b0;
    s_exp_q.delete(); exp_prev_q.delete();
    #2;
    chk("mid_rst_prev", s_prev, 0);
    chk("mid_rst_valid", s_ovalid, 0);
    chk("mid_rst_data", s_odata, 0);
    chk("mid_rst_last", s_olast, 0);
    chk("mid_rst_busy", s_busy, 0);
    chk("mid_rst_done", s_done, 0);
    chk("mid_rst_ovf", s_ovf, 0);
    @(posedge clk); #1 reset = 1'b1;
    s_fixed_frame(0);

    chk("leftover_out", s_exp_q.size(), 0);
    chk("leftover_d_out", d_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conva5_ofm_buffer.md
CONVA5_OFM_BUFFER -- requirements
Module: conva5_ofm_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of every data word.
REQ-002 SHALL have parameter NUMBER_OF_FILTERS, default 160: partial sums held, one per filter.
REQ-003 SHALL have parameter NUMBER_OF_PASSES, default 30: accumulation passes per frame, ceil(88 depth / 3 units).
REQ-004 SHALL have port clk  input  1: single clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1: one-cycle pulse that begins a frame.
REQ-007 SHALL have port wr_enable  input  1: data_in is valid this cycle.
REQ-008 SHALL have port data_in  input  DATA_WIDTH: ReLU/accumulator result from the conv datapath.
REQ-009 SHALL have port rd_enable  input  1: request the next stored partial sum.
REQ-010 SHALL have port data_out_for_previous  output  DATA_WIDTH: partial sum fed back to the conv accumulator.
REQ-011 SHALL have port out_valid  output  1: out_data holds a final result.
REQ-012 SHALL have port out_ready  input  1: the downstream FC stage accepts out_data.
REQ-013 SHALL have port out_data  output  DATA_WIDTH: final filter result.
REQ-014 SHALL have port out_last  output  1: out_data is the filter NUMBER_OF_FILTERS-1 result.
REQ-015 SHALL have port busy  output  1: state is not IDLE.
REQ-016 SHALL have port done  output  1: one-cycle pulse after the last handshake.
REQ-017 SHALL have port overflow_error  output  1: sticky flag for a write outside ACCUM.

Function
REQ-018 SHALL implement three states: IDLE, ACCUM and DRAIN.
REQ-019 SHALL go IDLE->ACCUM on start and clear the write pointer, read pointer and pass counter in that transition.
REQ-020 SHALL ignore start while in ACCUM or DRAIN.
REQ-021 SHALL, in ACCUM, write data_in at the write pointer on wr_enable and then increment the pointer.
REQ-022 SHALL wrap the write pointer from NUMBER_OF_FILTERS-1 to 0 and increment the pass counter on that wrap.
REQ-023 SHALL, in ACCUM, read the read pointer on rd_enable, present the value on data_out_for_previous exactly 1 cycle later, then increment the pointer with the same wrap rule.
REQ-024 SHALL hold data_out_for_previous when no read occurs.
REQ-025 SHALL return the pre-write (old) value when a read and a write hit the same address in the same cycle.
REQ-026 SHALL go ACCUM->DRAIN on the write that brings the pass counter to NUMBER_OF_PASSES.
REQ-027 SHALL, in DRAIN, stream addresses 0..NUMBER_OF_FILTERS-1 in order with a valid/ready handshake.
REQ-028 SHALL count a transfer only when out_valid and out_ready are both high in the same cycle.
REQ-029 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-030 SHALL sustain one transfer per cycle when out_ready is held high, using prefetch/skid so no bubbles occur.
REQ-031 SHALL assert out_last only with the final word.
REQ-032 SHALL, after the final transfer, return to IDLE and pulse done for 1 cycle.
REQ-033 SHALL ignore wr_enable in IDLE or DRAIN (no memory write) and set overflow_error, cleared only by reset.
REQ-034 SHALL ignore rd_enable outside ACCUM.
REQ-035 SHALL move data unmodified: no arithmetic, no width change.

Reset
REQ-036 SHALL, while reset=0, asynchronously force state=IDLE and set all pointers, the pass counter, out_valid, out_last, done, busy and overflow_error to 0.
REQ-037 SHALL set out_data and data_out_for_previous to 0 on reset.
REQ-038 SHALL NOT clear memory contents on reset.
REQ-039 SHALL abandon a frame on reset mid-frame; a new start is then required.

Structure
REQ-040 SHALL take state encodings and the NUMBER_OF_PASSES derivation from shared package conva5_ofm_pkg.
REQ-041 SHALL hold storage in one sub-module, ofm_dual_port_memory: NUMBER_OF_FILTERS x DATA_WIDTH, one write port, one synchronous read port.

Verification (NUMBER_OF_FILTERS=4, NUMBER_OF_PASSES=3 unless stated)
REQ-042 SHALL verify: start, then 3 passes of writes 1..4, 11..14, 21..24 -> out_data 21,22,23,24 with out_last on 24, then done pulses once.
REQ-043 SHALL verify: pass-2 rd_enable on address 2 -> data_out_for_previous=3 next cycle; same-cycle write 13 to address 2 -> read still returns 3.
REQ-044 SHALL verify: out_ready low for 3 cycles on word 2 of DRAIN -> out_data=22 held, no skip or duplicate, 4 transfers total.
REQ-045 SHALL verify: wr_enable with data 99 in IDLE -> overflow_error=1 and a later drain never outputs 99.
REQ-046 SHALL verify: reset at pass 2 address 1 -> all outputs 0, state IDLE, then a fresh frame completes correctly.
REQ-047 SHALL verify, at defaults: 30x160 writes with out_ready=1 -> 160 consecutive transfers with no gaps.
